freqdivider_prog: RTL

Parametrised, runtime-programmable clock divider for the digital clock datapath. It divides the single system clock by a loadable divisor and produces a 50 % duty square wave plus a one-cycle tick per half-period. The tick feeds seconds/multiplex counters; the square wave drives visible blink and scan outputs. Divisor changes are glitch-free, and enable/hold is supported.

---
 rtl/freqdiv_pkg.sv | 10 +
 rtl/freqdiv_counter.sv | 30 +++
 rtl/freqdivider_prog.sv | 87 ++++++++
 3 files changed

// File: rtl/freqdiv_pkg.sv
// Shared widths, rate constants and divisor type for the clock divider slice.
package freqdiv_pkg;

    localparam int unsigned DIV_WIDTH    = 20;
    localparam int unsigned DIV_1HZ_HALF = 250000;
    localparam int unsigned DIV_SCAN     = 2500;

    typedef logic [DIV_WIDTH-1:0] div_t;

endpackage

// File: rtl/freqdiv_counter.sv
// Half-period counter: counts enabled cycles and flags the terminal count of divisor-1.
module freqdiv_counter
    import freqdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] divisor,
    output logic             terminal
);

    logic [WIDTH-1:0] r_count;

    // divisor is already forced to at least 1 by the parent, so divisor-1 never wraps
    assign terminal = enable && (r_count == divisor - WIDTH'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear || terminal) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/freqdivider_prog.sv
// Programmable 50% clock divider with per-half-period tick and glitch-free divisor reload.
// FREQDIV_IMMEDIATE_LOAD_EN: div_load rewrites the divisor at once and restarts the count.
module freqdivider_prog
    import freqdiv_pkg::*;
#(
    parameter int unsigned WIDTH       = DIV_WIDTH,
    parameter int unsigned DIV_DEFAULT = DIV_1HZ_HALF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending
);

    logic [WIDTH-1:0] r_active;
    logic [WIDTH-1:0] r_pending;
    logic             r_pending_valid;
    logic             r_clk_out;
    logic             r_tick;

    logic [WIDTH-1:0] w_div_eff;
    logic             w_terminal;
    logic             w_clear;
    logic             w_toggle;

    assign w_div_eff = (r_active == '0) ? WIDTH'(1) : r_active;

`ifdef FREQDIV_IMMEDIATE_LOAD_EN
    assign w_clear = div_load;
`else
    assign w_clear = 1'b0;
`endif

    // An immediate load suppresses a coincident terminal so no toggle slips through
    assign w_toggle = w_terminal && !w_clear;

    freqdiv_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (clock),
        .rst_n    (reset_n),
        .enable   (enable),
        .clear    (w_clear),
        .divisor  (w_div_eff),
        .terminal (w_terminal)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_active        <= WIDTH'(DIV_DEFAULT);
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_clk_out       <= 1'b0;
            r_tick          <= 1'b0;
        end else begin
            r_tick <= w_toggle;
            if (w_toggle) begin
                r_clk_out <= ~r_clk_out;
            end
`ifdef FREQDIV_IMMEDIATE_LOAD_EN
            r_pending_valid <= 1'b0;
            if (div_load) begin
                r_active <= div_in;
            end
`else
            if (w_toggle && r_pending_valid) begin
                r_active        <= r_pending;
                r_pending_valid <= 1'b0;
            end
            // Placed after the apply so a same-edge load re-arms the pending slot
            if (div_load) begin
                r_pending       <= div_in;
                r_pending_valid <= 1'b1;
            end
`endif
        end
    end

    assign clk_out     = r_clk_out;
    assign tick        = r_tick;
    assign div_pending = r_pending_valid;

endmodule
